// File: rtl/bist_chk66_if.sv
// 66b receive block bus into the BIST checker: payload, sync header and valid qualifier.
interface bist_chk66_if;
    logic [63:0] RX_DAT;
    logic [1:0]  RX_SH;
    logic        RX_VAL;

    modport master (output RX_DAT, RX_SH, RX_VAL);
    modport slave  (input  RX_DAT, RX_SH, RX_VAL);
endinterface

// File: rtl/bist_chk66.sv
// Receive-side PRBS31 BIST checker for 66b blocks: self-syncs in HUNT, free-runs the reference in LOCKED.
// Optional macro BIST_CHK_SH_ERR_EN routes bad sync headers to SH_ERR_CNT instead of the block/bit error counters.
module bist_chk66 #(
    parameter int LOCK_CNT = 16,
    parameter int LOSS_CNT = 4,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             chk_en,
    input  logic             cnt_clr,
    bist_chk66_if.slave      rx,
    output logic             LOCKED,
    output logic [CNT_W-1:0] BLK_CNT,
    output logic [CNT_W-1:0] BLK_ERR_CNT,
    output logic [CNT_W-1:0] BIT_ERR_CNT,
    output logic [CNT_W-1:0] IDLE_CNT,
    output logic [CNT_W-1:0] SH_ERR_CNT
);
    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int LOSS_W = $clog2(LOSS_CNT + 1);
    localparam int SUM_W  = CNT_W + 8;

    typedef enum logic [1:0] {ST_IDLE, ST_HUNT, ST_LOCKED} state_t;

    // Next 64 stream bits after block p; bits from index 28 on depend on bits of the new block itself.
    function automatic logic [63:0] prbs_nxt(input logic [63:0] p);
        logic [63:0] q;
        q = '0;
        for (int i = 0; i < 28; i++)  q[i] = p[33+i] ^ p[36+i];
        for (int i = 28; i < 31; i++) q[i] = p[33+i] ^ q[i-28];
        for (int i = 31; i < 64; i++) q[i] = q[i-31] ^ q[i-28];
        return q;
    endfunction

    function automatic logic [6:0] popcnt64(input logic [63:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) n = n + {6'd0, v[i]};
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [6:0] inc);
        logic [SUM_W-1:0] s;
        s = {8'd0, c} + {{(SUM_W-7){1'b0}}, inc};
        if (s > {8'd0, {CNT_W{1'b1}}}) return {CNT_W{1'b1}};
        return s[CNT_W-1:0];
    endfunction

    logic [63:0]      dat_p1_d, dat_p1_q;
    logic [1:0]       sh_p1_d, sh_p1_q;
    logic             vld_p1_d, vld_p1_q;
    state_t           state_d, state_q;
    logic [63:0]      ref_d, ref_q;
    logic             seed_d, seed_q;
    logic [RUN_W-1:0] run_d, run_q;
    logic [LOSS_W-1:0] loss_d, loss_q;
    logic [CNT_W-1:0] blk_cnt_d, blk_cnt_q, blk_err_d, blk_err_q;
    logic [CNT_W-1:0] bit_err_d, bit_err_q, idle_cnt_d, idle_cnt_q;
    logic [63:0]      exp_blk, diff;
    logic             is_data, is_idle, is_bad, active;
    logic             blk_inc, err_inc, miss;
    logic [6:0]       bit_inc;

    // stage 1: register the incoming block
    always_comb begin
        dat_p1_d = rx.RX_DAT;
        sh_p1_d  = rx.RX_SH;
        vld_p1_d = rx.RX_VAL;
    end

    always_ff @(posedge clk) begin
        dat_p1_q <= dat_p1_d;
        sh_p1_q  <= sh_p1_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_p1_q <= 1'b0;
        else        vld_p1_q <= vld_p1_d;
    end

    // stage 2: classify, compare and update state/counters
    assign is_data = (sh_p1_q == 2'b10);
    assign is_idle = (sh_p1_q == 2'b01) && (dat_p1_q[7:0] == 8'h1E);
    assign is_bad  = (sh_p1_q == 2'b00) || (sh_p1_q == 2'b11);
    assign active  = chk_en && (state_q != ST_IDLE) && vld_p1_q;
    // In HUNT ref_q holds the last received block, in LOCKED the free-running expectation.
    assign exp_blk = prbs_nxt(ref_q);
    assign diff    = dat_p1_q ^ exp_blk;

    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        seed_d  = seed_q;
        run_d   = run_q;
        loss_d  = loss_q;
        blk_inc = 1'b0;
        err_inc = 1'b0;
        bit_inc = '0;
        miss    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (chk_en) begin
                    state_d = ST_HUNT;
                    seed_d  = 1'b0;
                    run_d   = '0;
                    loss_d  = '0;
                end
            end
            ST_HUNT: begin
                if (!chk_en) begin
                    state_d = ST_IDLE;
                end else if (vld_p1_q && !is_idle) begin
                    if (is_data) begin
                        ref_d  = dat_p1_q;
                        seed_d = 1'b1;
                        if (seed_q && (diff == '0)) begin
                            if (run_q == RUN_W'(LOCK_CNT - 1)) begin
                                state_d = ST_LOCKED;
                                run_d   = '0;
                                loss_d  = '0;
                            end else begin
                                run_d = run_q + RUN_W'(1);
                            end
                        end else begin
                            run_d = '0;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (!chk_en) begin
                    state_d = ST_IDLE;
                end else if (vld_p1_q && !is_idle) begin
                    ref_d = exp_blk;
                    if (is_data) begin
                        blk_inc = 1'b1;
                        if (diff != '0) begin
                            err_inc = 1'b1;
                            bit_inc = popcnt64(diff);
                            miss    = 1'b1;
                        end
                    end else if (is_bad) begin
`ifdef BIST_CHK_SH_ERR_EN
                        miss    = 1'b1;
`else
                        err_inc = 1'b1;
                        bit_inc = 7'd64;
                        miss    = 1'b1;
`endif
                    end else begin
                        err_inc = 1'b1;
                        bit_inc = 7'd64;
                        miss    = 1'b1;
                    end
                    if (!miss) begin
                        loss_d = '0;
                    end else if (loss_q == LOSS_W'(LOSS_CNT - 1)) begin
                        state_d = ST_HUNT;
                        loss_d  = '0;
                        run_d   = '0;
                        seed_d  = 1'b0;
                    end else begin
                        loss_d = loss_q + LOSS_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        blk_cnt_d  = blk_cnt_q;
        blk_err_d  = blk_err_q;
        bit_err_d  = bit_err_q;
        idle_cnt_d = idle_cnt_q;
        if (cnt_clr) begin
            blk_cnt_d  = '0;
            blk_err_d  = '0;
            bit_err_d  = '0;
            idle_cnt_d = '0;
        end else begin
            if (blk_inc)          blk_cnt_d  = sat_add(blk_cnt_q, 7'd1);
            if (err_inc)          blk_err_d  = sat_add(blk_err_q, 7'd1);
            if (active && is_idle) idle_cnt_d = sat_add(idle_cnt_q, 7'd1);
            bit_err_d = sat_add(bit_err_q, bit_inc);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ref_q      <= '0;
            seed_q     <= 1'b0;
            run_q      <= '0;
            loss_q     <= '0;
            blk_cnt_q  <= '0;
            blk_err_q  <= '0;
            bit_err_q  <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ref_q      <= ref_d;
            seed_q     <= seed_d;
            run_q      <= run_d;
            loss_q     <= loss_d;
            blk_cnt_q  <= blk_cnt_d;
            blk_err_q  <= blk_err_d;
            bit_err_q  <= bit_err_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

`ifdef BIST_CHK_SH_ERR_EN
    logic [CNT_W-1:0] sh_err_d, sh_err_q;

    always_comb begin
        sh_err_d = sh_err_q;
        if (cnt_clr)              sh_err_d = '0;
        else if (active && is_bad) sh_err_d = sat_add(sh_err_q, 7'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sh_err_q <= '0;
        else        sh_err_q <= sh_err_d;
    end

    assign SH_ERR_CNT = sh_err_q;
`else
    assign SH_ERR_CNT = '0;
`endif

    assign LOCKED      = (state_q == ST_LOCKED);
    assign BLK_CNT     = blk_cnt_q;
    assign BLK_ERR_CNT = blk_err_q;
    assign BIT_ERR_CNT = bit_err_q;
    assign IDLE_CNT    = idle_cnt_q;
endmodule

// File: tb/tb_bist_chk66.sv
// Bench for bist_chk66: random PRBS31 stream with directed error/idle events, checked against a bit-serial model.
`timescale 1ns/1ps
module tb_bist_chk66;
    localparam int     CW   = 32;
    localparam longint MAXC = (64'd1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, chk_en, cnt_clr, rst4_n, chk_en4, cnt_clr4;
    logic locked, locked4;
    logic [CW-1:0] blk_cnt, blk_err, bit_err, idle_cnt, sh_err;
    logic [3:0]    blk_cnt4, blk_err4, bit_err4, idle_cnt4, sh_err4;

    bist_chk66_if rx_if();

    bist_chk66 #(.LOCK_CNT(16), .LOSS_CNT(4), .CNT_W(CW)) u_dut (
        .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .cnt_clr(cnt_clr), .rx(rx_if),
        .LOCKED(locked), .BLK_CNT(blk_cnt), .BLK_ERR_CNT(blk_err), .BIT_ERR_CNT(bit_err),
        .IDLE_CNT(idle_cnt), .SH_ERR_CNT(sh_err)
    );

    bist_chk66 #(.LOCK_CNT(16), .LOSS_CNT(4), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst4_n), .chk_en(chk_en4), .cnt_clr(cnt_clr4), .rx(rx_if),
        .LOCKED(locked4), .BLK_CNT(blk_cnt4), .BLK_ERR_CNT(blk_err4), .BIT_ERR_CNT(bit_err4),
        .IDLE_CNT(idle_cnt4), .SH_ERR_CNT(sh_err4)
    );

    int n_chk, n_pass, n_fail;

    // Stream generator state: g_h[k] = s[n-31+k]
    logic [30:0] g_h;

    // Reference model of the main checker
    int          m_state;   // 0 idle, 1 hunt, 2 locked
    bit          m_seeded;
    int          m_run, m_loss;
    logic [63:0] m_ref;
    longint      m_blk, m_berr, m_bit, m_idle, m_sh;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint sat(input longint v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    function automatic logic [63:0] ref_next(input logic [63:0] p);
        bit          s[128];
        logic [63:0] r;
        for (int i = 0; i < 64; i++) s[i] = p[i];
        for (int n = 64; n < 128; n++) s[n] = s[n-31] ^ s[n-28];
        for (int i = 0; i < 64; i++) r[i] = s[64+i];
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0; m_seeded = 0; m_run = 0; m_loss = 0; m_ref = '0;
        m_blk = 0; m_berr = 0; m_bit = 0; m_idle = 0; m_sh = 0;
    endtask

    task automatic model_enable();
        m_state = 1; m_seeded = 0; m_run = 0; m_loss = 0;
    endtask

    task automatic model_blk(input logic [63:0] dat, input logic [1:0] sh);
        logic [63:0] e;
        int          nb;
        bit          bad;
        if (m_state == 0) return;
        if (sh == 2'b01 && dat[7:0] == 8'h1E) begin
            m_idle = sat(m_idle + 1);
            return;
        end
`ifdef BIST_CHK_SH_ERR_EN
        if (sh == 2'b00 || sh == 2'b11) m_sh = sat(m_sh + 1);
`endif
        if (m_state == 1) begin
            if (sh == 2'b10) begin
                if (m_seeded && dat == ref_next(m_ref)) m_run = m_run + 1;
                else m_run = 0;
                m_seeded = 1;
                m_ref = dat;
                if (m_run == 16) begin m_state = 2; m_run = 0; m_loss = 0; end
            end else begin
                m_run = 0;
            end
        end else begin
            e = ref_next(m_ref);
            m_ref = e;
            bad = 0;
            if (sh == 2'b10) begin
                m_blk = sat(m_blk + 1);
                nb = $countones(dat ^ e);
                if (nb > 0) begin m_berr = sat(m_berr + 1); m_bit = sat(m_bit + nb); bad = 1; end
            end else if (sh == 2'b01) begin
                m_berr = sat(m_berr + 1); m_bit = sat(m_bit + 64); bad = 1;
            end else begin
`ifndef BIST_CHK_SH_ERR_EN
                m_berr = sat(m_berr + 1); m_bit = sat(m_bit + 64);
`endif
                bad = 1;
            end
            if (bad) begin
                m_loss = m_loss + 1;
                if (m_loss == 4) begin m_state = 1; m_seeded = 0; m_run = 0; m_loss = 0; end
            end else begin
                m_loss = 0;
            end
        end
    endtask

    task automatic gen_blk(output logic [63:0] b);
        for (int i = 0; i < 64; i++) begin
            b[i] = g_h[0] ^ g_h[3];
            g_h  = {b[i], g_h[30:1]};
        end
    endtask

    task automatic send_blk(input logic [63:0] dat, input logic [1:0] sh);
        @(negedge clk);
        rx_if.RX_DAT = dat;
        rx_if.RX_SH  = sh;
        rx_if.RX_VAL = 1'b1;
        model_blk(dat, sh);
    endtask

    task automatic send_data();
        logic [63:0] b;
        gen_blk(b);
        send_blk(b, 2'b10);
    endtask

    task automatic send_err();
        logic [63:0] b, m;
        logic [31:0] lo, hi;
        gen_blk(b);
        lo = $urandom();
        hi = $urandom();
        m  = {hi, lo} | 64'd1;
        send_blk(b ^ m, 2'b10);
    endtask

    task automatic send_idle();
        logic [63:0] d;
        logic [31:0] lo, hi;
        lo = $urandom();
        hi = $urandom();
        d  = {hi, lo};
        d[7:0] = 8'h1E;
        send_blk(d, 2'b01);
    endtask

    task automatic flush();
        repeat (2) begin
            @(negedge clk);
            rx_if.RX_VAL = 1'b0;
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_locked"}, locked, (m_state == 2));
        chk({tag, "_blk"}, blk_cnt, m_blk);
        chk({tag, "_berr"}, blk_err, m_berr);
        chk({tag, "_bit"}, bit_err, m_bit);
        chk({tag, "_idle"}, idle_cnt, m_idle);
        chk({tag, "_sh"}, sh_err, m_sh);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] b;
        longint      bit_before, berr_before;
        n_chk = 0; n_pass = 0; n_fail = 0;
        rst_n = 1'b0; rst4_n = 1'b0;
        chk_en = 1'b0; chk_en4 = 1'b0; cnt_clr = 1'b0; cnt_clr4 = 1'b0;
        rx_if.RX_DAT = '0; rx_if.RX_SH = 2'b00; rx_if.RX_VAL = 1'b0;
        g_h = 31'($urandom()) | 31'd1;
        model_reset();

        repeat (3) @(negedge clk);
        chk_all("rst");
        chk("rst4_locked", locked4, 0);
        chk("rst4_berr", blk_err4, 0);
        chk("rst4_sh", sh_err4, 0);
        rst_n = 1'b1; rst4_n = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        model_enable();

        // Clean stream: lock after seed + 16 matches, then count
        for (int i = 1; i <= 100; i++) begin
            send_data();
            if (i == 17) begin
                @(negedge clk);
                rx_if.RX_VAL = 1'b0;
                chk("t1_lat_pre", locked, 0);
                @(negedge clk);
                chk("t1_lat", locked, 1);
            end
        end
        flush();
        chk_all("t1");
        chk("t1_blk83", blk_cnt, 83);
        chk("t1_berr0", blk_err, 0);

        // Single block with bits 0, 5, 63 flipped
        repeat (3) send_data();
        gen_blk(b);
        send_blk(b ^ 64'h8000_0000_0000_0021, 2'b10);
        send_data();
        flush();
        chk_all("t2");
        chk("t2_berr1", blk_err, 1);
        chk("t2_bit3", bit_err, 3);

        // Idle insertion/deletion: scheduled at 4,9,14,19 (9,14 deleted), inserted at 2,7,11
        for (int k = 0; k < 20; k++) begin
            send_data();
            if (k == 4 || k == 19 || k == 2 || k == 7 || k == 11) send_idle();
        end
        flush();
        chk_all("t3");
        chk("t3_idle5", idle_cnt, 5);
        chk("t3_berr1", blk_err, 1);

        // Four consecutive corrupted blocks drop lock, 17 clean relock
        repeat (4) send_err();
        flush();
        chk_all("t4_loss");
        chk("t4_unlocked", locked, 0);
        chk("t4_berr5", blk_err, 5);
        chk("t4_blk112", blk_cnt, 112);
        repeat (16) send_data();
        flush();
        chk("t4_hunt16", locked, 0);
        send_data();
        flush();
        chk("t4_relock", locked, 1);
        chk_all("t4");

        // Bad sync header while locked
        berr_before = m_berr;
        bit_before  = m_bit;
        repeat (2) send_data();
        gen_blk(b);
        send_blk(b, 2'b11);
        repeat (2) send_data();
        flush();
        chk_all("t5");
        chk("t5_locked", locked, 1);
`ifdef BIST_CHK_SH_ERR_EN
        chk("t5_sh1", sh_err, 1);
        chk("t5_berr", blk_err, berr_before);
`else
        chk("t5_sh0", sh_err, 0);
        chk("t5_berr", blk_err, berr_before + 1);
        chk("t5_bit64", bit_err, bit_before + 64);
`endif

        // Narrow counters saturate; clear beats increment; async reset
        @(negedge clk);
        chk_en4 = 1'b1;
        repeat (17) send_data();
        for (int k = 0; k < 20; k++) begin
            send_err();
            send_data();
        end
        flush();
        chk("t6_locked4", locked4, 1);
        chk("t6_berr4", blk_err4, 4'hF);
        chk("t6_bit4", bit_err4, 4'hF);
        chk("t6_blk4", blk_cnt4, 4'hF);
        chk_all("t6_main");
        send_err();
        @(negedge clk);
        rx_if.RX_VAL = 1'b0;
        cnt_clr4 = 1'b1;
        @(negedge clk);
        cnt_clr4 = 1'b0;
        chk("t6_clr_berr4", blk_err4, 0);
        chk("t6_clr_bit4", bit_err4, 0);
        chk("t6_clr_blk4", blk_cnt4, 0);
        chk_all("t6_noclr");
        repeat (3) send_data();
        #2;
        rst_n = 1'b0;
        rst4_n = 1'b0;
        model_reset();
        #1;
        chk_all("t6_rst");
        chk("t6_rst_locked4", locked4, 0);
        chk("t6_rst_idle4", idle_cnt4, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rst4_n = 1'b1;
        rx_if.RX_VAL = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
